// File: rtl/pau_wb_buffer.sv
// pau_wb_buffer: credit-throttled result FIFO between the posit unit and CVA6 writeback.
// Define PAU_WB_BYPASS_EN to forward a result straight to writeback when the FIFO is empty.
module pau_wb_buffer #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     issue_valid_i,
  input  logic                     pau_ready_i,
  output logic                     issue_ready_o,
  input  logic                     pau_valid_i,
  input  logic [TRANS_ID_BITS-1:0] pau_trans_id_i,
  input  logic [XLEN-1:0]          pau_result_i,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [XLEN-1:0]          wb_result_o
);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  logic [CW-1:0] count_q, count_d, inflight_q, inflight_d, drop_q, drop_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [TRANS_ID_BITS-1:0] id_q [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic credit, issue_fire, ret_ok, drop, keep, byp, pop, pop_fifo, push;
  assign credit        = ({1'b0, inflight_q} + {1'b0, count_q}) < (CW+1)'(DEPTH);
  assign issue_ready_o = rst_ni & pau_ready_i & ~flush_i & credit;
  assign issue_fire    = issue_valid_i & issue_ready_o;
  // A return with nothing in flight is a protocol error and is ignored.
  assign ret_ok = pau_valid_i & (inflight_q != '0);
  assign drop   = ret_ok & (drop_q != '0);
  assign keep   = ret_ok & ~drop;
`ifdef PAU_WB_BYPASS_EN
  assign byp = keep & (count_q == '0) & ~flush_i;
`else
  assign byp = 1'b0;
`endif
  assign wb_valid_o    = rst_ni & ~flush_i & ((count_q != '0) | byp);
  assign wb_trans_id_o = byp ? pau_trans_id_i : id_q[rd_q];
  assign wb_result_o   = byp ? pau_result_i : data_q[rd_q];
  assign pop      = wb_valid_o & wb_ready_i;
  assign pop_fifo = pop & (count_q != '0);
  assign push     = keep & ~(byp & wb_ready_i);
  always_comb begin
    inflight_d = inflight_q + CW'(issue_fire) - CW'(ret_ok);
    drop_d     = flush_i ? inflight_q - CW'(ret_ok) : drop_q - CW'(drop);
    count_d    = flush_i ? '0 : count_q + CW'(push) - CW'(pop_fifo);
    rd_d       = flush_i ? '0 : rd_q + PW'(pop_fifo);
    wr_d       = flush_i ? '0 : wr_q + PW'(push);
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q    <= '0;
      inflight_q <= '0;
      drop_q     <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
    end else begin
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_ni & push & ~flush_i) begin
      id_q[wr_q]   <= pau_trans_id_i;
      data_q[wr_q] <= pau_result_i;
    end
  end
  a_no_stray_return: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pau_valid_i && inflight_q == '0));
endmodule

// File: tb/tb_pau_wb_buffer.sv
// tb_pau_wb_buffer: directed stimulus with an expected-result queue checked by a writeback monitor.
module tb_pau_wb_buffer;
  localparam int XL = 64;
  localparam int TB = 3;
`ifdef PAU_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0, flush_i = 1'b0, issue_valid_i = 1'b0, pau_ready_i = 1'b1;
  logic pau_valid_i = 1'b0, wb_ready_i = 1'b0;
  logic [TB-1:0] pau_trans_id_i = '0;
  logic [XL-1:0] pau_result_i = '0;
  logic issue_ready_o, wb_valid_o;
  logic [TB-1:0] wb_trans_id_o;
  logic [XL-1:0] wb_result_o;
  logic [TB+XL-1:0] exp_q[$];
  int checks = 0, errors = 0;

  pau_wb_buffer #(.DEPTH(4), .XLEN(XL), .TRANS_ID_BITS(TB)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .pau_ready_i(pau_ready_i), .issue_ready_o(issue_ready_o),
    .pau_valid_i(pau_valid_i), .pau_trans_id_i(pau_trans_id_i), .pau_result_i(pau_result_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_trans_id_o(wb_trans_id_o), .wb_result_o(wb_result_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (wb_valid_o && wb_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected got id %0d data %0h required no output", wb_trans_id_o, wb_result_o);
      end else begin
        logic [TB+XL-1:0] e;
        e = exp_q.pop_front();
        if ({wb_trans_id_o, wb_result_o} !== e) begin
          errors++;
          $display("FAIL wb_data got id %0d data %0h required id %0d data %0h",
                   wb_trans_id_o, wb_result_o, e[TB+XL-1:XL], e[XL-1:0]);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h required %0h", n, a, e);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic issue_n(input int n);
    for (int i = 0; i < n; i++) begin
      issue_valid_i = 1'b1;
      #1 chk("issue_ready_credit", issue_ready_o, 1);
      tick();
      issue_valid_i = 1'b0;
    end
  endtask

  task automatic ret(input logic [TB-1:0] id, input logic [XL-1:0] d, input bit keep);
    pau_valid_i = 1'b1;
    pau_trans_id_i = id;
    pau_result_i = d;
    if (keep) exp_q.push_back({id, d});
    tick();
    pau_valid_i = 1'b0;
  endtask

  initial begin
    // reset
    tick(); tick();
    #1 chk("rst_issue_ready", issue_ready_o, 0);
    chk("rst_wb_valid", wb_valid_o, 0);
    rst_ni = 1'b1;
    tick();
    #1 chk("post_rst_issue_ready", issue_ready_o, 1);
    chk("post_rst_wb_valid", wb_valid_o, 0);
    pau_ready_i = 1'b0;
    #1 chk("pau_not_ready", issue_ready_o, 0);
    pau_ready_i = 1'b1;

    // single op
    issue_n(1);
    wb_ready_i = 1'b1;
    pau_valid_i = 1'b1; pau_trans_id_i = 3; pau_result_i = 64'h4000_0000;
    exp_q.push_back({3'd3, 64'h4000_0000});
    #1 chk("single_valid_ret_cycle", wb_valid_o, BYP);
    tick();
    pau_valid_i = 1'b0;
    #1 chk("single_valid_next", wb_valid_o, !BYP);
    tick();
    #1 chk("single_valid_after", wb_valid_o, 0);

    // backpressure
    wb_ready_i = 1'b0;
    issue_n(4);
    #1 chk("bp_issue_blocked", issue_ready_o, 0);
    for (int i = 0; i < 4; i++) ret(TB'(4 + i), 64'h1000 + 64'(i), 1);
    #1 chk("bp_full_blocked", issue_ready_o, 0);
    chk("bp_valid", wb_valid_o, 1);
    wb_ready_i = 1'b1;
    #1 chk("bp_credit_not_yet", issue_ready_o, 0);
    tick();
    #1 chk("bp_credit_back", issue_ready_o, 1);
    tick(); tick(); tick();
    #1 chk("bp_drained", wb_valid_o, 0);

    // flush with 2 buffered, 2 in flight
    wb_ready_i = 1'b0;
    issue_n(4);
    ret(0, 64'h2000, 1);
    ret(1, 64'h2001, 1);
    flush_i = 1'b1;
    #1 chk("flush_valid_low", wb_valid_o, 0);
    chk("flush_issue_low", issue_ready_o, 0);
    exp_q.delete();
    tick();
    flush_i = 1'b0;
    #1 chk("post_flush_valid", wb_valid_o, 0);
    wb_ready_i = 1'b1;
    ret(2, 64'h2002, 0);
    ret(3, 64'h2003, 0);
    #1 chk("drops_no_output", wb_valid_o, 0);
    chk("drops_credit", issue_ready_o, 1);
    issue_n(1);
    ret(4, 64'h2004, 1);
    tick(); tick();

    // flush coinciding with a return at inflight = 1
    issue_n(1);
    pau_valid_i = 1'b1; pau_trans_id_i = 5; pau_result_i = 64'h3005; flush_i = 1'b1;
    tick();
    pau_valid_i = 1'b0; flush_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("flush_ret_quiet", wb_valid_o, 0);
      tick();
    end
    issue_n(1);
    ret(6, 64'h3006, 1);
    tick(); tick();

    // simultaneous push and pop at count = 2
    wb_ready_i = 1'b0;
    issue_n(2);
    ret(0, 64'h500, 1);
    ret(1, 64'h501, 1);
    issue_n(1);
    wb_ready_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      issue_valid_i = 1'b1;
      pau_valid_i = 1'b1;
      pau_trans_id_i = TB'(k + 2);
      pau_result_i = 64'h600 + 64'(k);
      exp_q.push_back({pau_trans_id_i, pau_result_i});
      #1 chk("pp_issue_ready", issue_ready_o, 1);
      chk("pp_valid", wb_valid_o, 1);
      tick();
    end
    issue_valid_i = 1'b0;
    ret(4, 64'h700, 1);
    tick(); tick(); tick();
    #1 chk("pp_drained", wb_valid_o, 0);

    // reset mid-drain with count = 3
    wb_ready_i = 1'b0;
    issue_n(4);
    for (int i = 0; i < 4; i++) ret(TB'(5 + i), 64'h800 + 64'(i), 1);
    wb_ready_i = 1'b1;
    tick();
    rst_ni = 1'b0;
    #1 chk("midrst_valid", wb_valid_o, 0);
    chk("midrst_issue", issue_ready_o, 0);
    exp_q.delete();
    tick();
    rst_ni = 1'b1;
    #1 chk("after_rst_valid", wb_valid_o, 0);
    chk("after_rst_issue", issue_ready_o, 1);
    pau_ready_i = 1'b0;
    #1 chk("after_rst_issue_follow", issue_ready_o, 0);
    pau_ready_i = 1'b1;
    tick();
    #1 chk("after_rst_still_empty", wb_valid_o, 0);
    chk("queue_empty", 64'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
